// File: rtl/input_write_arbiter.sv
// Two-requester round-robin burst arbiter feeding the 32-bit input FIFO write
// port. Each grant lasts up to BURST_LEN words and holds while the FIFO
// reports almost-full. The write toward the FIFO is registered, and a running
// count of committed words is kept.
module input_write_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 32
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  input  logic             Req0ValidxSI,
  input  logic [31:0]      Req0DataxDI,
  output logic             Req0ReadyxSO,
  input  logic             Req1ValidxSI,
  input  logic [31:0]      Req1DataxDI,
  output logic             Req1ReadyxSO,
  input  logic             FifoBusyxSI,
  output logic             FifoWexSO,
  output logic [31:0]      FifoDInxDO,
  output logic [1:0]       GrantxSO,
  output logic [CNT_W-1:0] WordCntxDO
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  // The burst counter reaches this value on the last word of a burst.
  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  burst_cnt, burst_cnt_nxt;
  logic        last_srv, last_srv_nxt;   // index of the requester served most recently
  logic        xfer;
  logic [31:0] xfer_data;
  logic        own_sel;                  // 1 when the current grant belongs to requester 1
  logic        own_vld, oth_vld;

  // While the FIFO is busy, the current owner stalls but keeps its grant.
  assign Req0ReadyxSO = (state == G0) & ~FifoBusyxSI;
  assign Req1ReadyxSO = (state == G1) & ~FifoBusyxSI;
  assign xfer         = (Req0ReadyxSO & Req0ValidxSI) | (Req1ReadyxSO & Req1ValidxSI);
  assign xfer_data    = (state == G1) ? Req1DataxDI : Req0DataxDI;
  assign GrantxSO     = {state == G1, state == G0};

  assign own_sel = (state == G1);
  assign own_vld = own_sel ? Req1ValidxSI : Req0ValidxSI;
  assign oth_vld = own_sel ? Req0ValidxSI : Req1ValidxSI;

  // Next-state logic: arbitration from IDLE, and burst release with an
  // immediate handover (no idle cycle) while a grant is held.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_srv_nxt  = last_srv;
    case (state)
      IDLE: begin
        if (Req0ValidxSI && (!Req1ValidxSI || last_srv)) begin
          state_nxt     = G0;
          last_srv_nxt  = 1'b0;
          burst_cnt_nxt = '0;
        end else if (Req1ValidxSI) begin
          state_nxt     = G1;
          last_srv_nxt  = 1'b1;
          burst_cnt_nxt = '0;
        end
      end
      G0, G1: begin
        if ((xfer && (burst_cnt == BURST_LAST)) || !own_vld) begin
          burst_cnt_nxt = '0;
          if (oth_vld) begin
            state_nxt    = own_sel ? G0 : G1;
            last_srv_nxt = ~own_sel;
          end else if (!own_vld) begin
            state_nxt = IDLE;
          end
          // Otherwise the burst is exhausted but the owner is still valid,
          // so it is regranted with a fresh counter.
        end else if (xfer) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_srv  <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last_srv  <= last_srv_nxt;
    end
  end

  // Registered FIFO write. The data register holds between writes.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      FifoWexSO  <= 1'b0;
      FifoDInxDO <= '0;
    end else begin
      FifoWexSO <= xfer;
      if (xfer) FifoDInxDO <= xfer_data;
    end
  end

  // The count advances on each edge where the FIFO commits a word.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) WordCntxDO <= '0;
    else        WordCntxDO <= WordCntxDO + {{(CNT_W-1){1'b0}}, FifoWexSO};
  end

endmodule

// File: tb/tb_input_write_arbiter.sv
// Bench for input_write_arbiter (BURST_LEN=4, CNT_W=4). It runs a directed
// vector table, a reset-mid-transfer sequence, a 17-word wrap stream and
// randomized traffic checked against a reference model.
module tb_input_write_arbiter;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0, v0 = 1'b0, v1 = 1'b0, busy = 1'b0;
  logic [31:0]   d0 = '0, d1 = '0;
  logic          r0, r1, we;
  logic [31:0]   din;
  logic [1:0]    grant;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  input_write_arbiter #(.BURST_LEN(BL), .CNT_W(CW)) dut (
    .ClkxCI(clk), .RstxRI(rst),
    .Req0ValidxSI(v0), .Req0DataxDI(d0), .Req0ReadyxSO(r0),
    .Req1ValidxSI(v1), .Req1DataxDI(d1), .Req1ReadyxSO(r1),
    .FifoBusyxSI(busy), .FifoWexSO(we), .FifoDInxDO(din),
    .GrantxSO(grant), .WordCntxDO(cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = requester 0, 2 = requester 1.
  int          m_own, m_last, m_words, m_cnt;
  logic        m_we, m_acc0, m_acc1;
  logic [31:0] m_din;

  function automatic void m_reset();
    m_own = 0; m_last = 1; m_words = 0; m_cnt = 0;
    m_we = 1'b0; m_din = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
  endfunction

  function automatic void m_step();
    bit mine, theirs;
    if (rst) begin
      m_reset();
      return;
    end
    m_acc0 = (m_own == 1) && v0 && !busy;
    m_acc1 = (m_own == 2) && v1 && !busy;
    m_cnt  = (m_cnt + int'(m_we)) % (1 << CW);
    m_we   = m_acc0 | m_acc1;
    if (m_acc0) m_din = d0;
    if (m_acc1) m_din = d1;
    if (m_own == 0) begin
      if (v0 && v1)  m_own = (m_last == 1) ? 1 : 2;
      else if (v0)   m_own = 1;
      else if (v1)   m_own = 2;
      if (m_own != 0) begin
        m_last  = m_own - 1;
        m_words = 0;
      end
    end else begin
      mine   = (m_own == 1) ? v0 : v1;
      theirs = (m_own == 1) ? v1 : v0;
      if (m_we) m_words++;
      if ((m_we && m_words == BL) || !mine) begin
        m_words = 0;
        if (theirs) begin
          m_own  = 3 - m_own;
          m_last = m_own - 1;
        end else if (!mine) begin
          m_own = 0;
        end
      end
    end
  endfunction

  int pulses;
  bit saw_wrap;
  logic [CW-1:0] prev_cnt;

  // Drive one cycle from the negedge, compare against the model, then advance it.
  task automatic cyc(input logic r, input logic a0, input logic a1, input logic b,
                     input logic [31:0] x0, input logic [31:0] x1);
    logic [1:0] eg;
    rst = r; v0 = a0; v1 = a1; busy = b; d0 = x0; d1 = x1;
    #1;
    eg = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
    chk("grant", 32'(grant), 32'(eg));
    chk("rdy0",  32'(r0),  32'((m_own == 1) && !b));
    chk("rdy1",  32'(r1),  32'((m_own == 2) && !b));
    chk("we",    32'(we),  32'(m_we));
    chk("din",   din,      m_din);
    chk("cnt",   32'(cnt), 32'(m_cnt));
    if (we === 1'b1) pulses++;
    if (prev_cnt == 4'd15 && cnt == 4'd0) saw_wrap = 1'b1;
    prev_cnt = cnt;
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic r, a0, a1, b;
    logic [31:0] x0, x1;
    logic [1:0] g;
    logic e0, e1, ewe;
    logic [31:0] edin;
    logic [3:0] ecnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Burst of 4 from req0 with one busy stall, handover to req1, req1 drop,
    // req0 drop to idle, a tie resolved toward req1, and a short req1 grant.
    tbl[0]  = '{0,1,0,0,32'hA1,32'h0 ,2'b00,0,0,0,32'h0 ,4'd0};
    tbl[1]  = '{0,1,0,0,32'hA1,32'h0 ,2'b01,1,0,0,32'h0 ,4'd0};
    tbl[2]  = '{0,1,0,0,32'hA2,32'h0 ,2'b01,1,0,1,32'hA1,4'd0};
    tbl[3]  = '{0,1,1,1,32'hA3,32'hB1,2'b01,0,0,1,32'hA2,4'd1};
    tbl[4]  = '{0,1,1,0,32'hA3,32'hB1,2'b01,1,0,0,32'hA2,4'd2};
    tbl[5]  = '{0,1,1,0,32'hA4,32'hB1,2'b01,1,0,1,32'hA3,4'd2};
    tbl[6]  = '{0,1,1,0,32'hA5,32'hB1,2'b10,0,1,1,32'hA4,4'd3};
    tbl[7]  = '{0,1,0,0,32'hA5,32'hB2,2'b10,0,1,1,32'hB1,4'd4};
    tbl[8]  = '{0,0,0,0,32'hA5,32'hB2,2'b01,1,0,0,32'hB1,4'd5};
    tbl[9]  = '{0,1,1,0,32'hA5,32'hB2,2'b00,0,0,0,32'hB1,4'd5};
    tbl[10] = '{0,1,1,0,32'hA5,32'hB2,2'b10,0,1,0,32'hB1,4'd5};
    tbl[11] = '{0,0,0,0,32'hA5,32'hB2,2'b10,0,1,1,32'hB2,4'd5};
    tbl[12] = '{0,0,0,0,32'hA5,32'hB2,2'b00,0,0,0,32'hB2,4'd6};

    // Reset with both requesters valid: Ready must stay low in IDLE.
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rdy",   32'({r0, r1}), 32'h0);
    chk("rst_we",    32'(we), 32'h0);
    chk("rst_din",   din, 32'h0);
    chk("rst_cnt",   32'(cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; v0 = tbl[i].a0; v1 = tbl[i].a1; busy = tbl[i].b;
      d0 = tbl[i].x0; d1 = tbl[i].x1;
      #1;
      chk($sformatf("t%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("t%0d_rdy0", i),  32'(r0),  32'(tbl[i].e0));
      chk($sformatf("t%0d_rdy1", i),  32'(r1),  32'(tbl[i].e1));
      chk($sformatf("t%0d_we", i),    32'(we),  32'(tbl[i].ewe));
      chk($sformatf("t%0d_din", i),   din,      tbl[i].edin);
      chk($sformatf("t%0d_cnt", i),   32'(cnt), 32'(tbl[i].ecnt));
      @(posedge clk);
      @(negedge clk);
    end

    // Reset on the same edge as a req1 transfer: the word must be dropped.
    v0 = 1'b0; v1 = 1'b1; d1 = 32'hC1; busy = 1'b0; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rx_grant_pre", 32'(grant), 32'h2);
    chk("rx_rdy1_pre",  32'(r1), 32'h1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    #1;
    chk("rx_we",    32'(we), 32'h0);
    chk("rx_grant", 32'(grant), 32'h0);
    chk("rx_cnt",   32'(cnt), 32'h0);
    chk("rx_din",   din, 32'h0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("rx_we2", 32'(we), 32'h0);
    @(negedge clk);

    // 17-word stream from req0: the count wraps 15 -> 0 and then reads 1.
    m_reset();
    pulses = 0; saw_wrap = 1'b0; prev_cnt = '0;
    begin
      logic [31:0] w;
      w = 32'h1111_1111;
      for (int i = 0; i < 18; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, w, 32'h0);
        if (m_acc0) w = w + 32'h1111_1111;
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, w, 32'h0);
    end
    chk("wrap_pulses", 32'(pulses), 32'd17);
    chk("wrap_seen",   32'(saw_wrap), 32'd1);
    chk("wrap_cnt",    32'(cnt), 32'd1);

    // Randomized traffic against the model.
    begin
      logic a0, a1, b, r;
      logic [31:0] x0, x1;
      a0 = 1'b0; a1 = 1'b0; b = 1'b0;
      x0 = $urandom; x1 = $urandom;
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 7) == 0) a0 = ~a0;
        if ($urandom_range(0, 7) == 0) a1 = ~a1;
        if ($urandom_range(0, 5) == 0) b  = ~b;
        cyc(r, a0, a1, b, x0, x1);
        // New data only after a word is taken or while not offered.
        if (m_acc0 || !a0 || r) x0 = $urandom;
        if (m_acc1 || !a1 || r) x1 = $urandom;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_write_arbiter.md
Name: input_write_arbiter

Overview:
- Two-requester write scheduler in front of the 32-bit write port of the input FIFO.
- Shares that port between two word sources, for example host DMA and a register-mapped load port, using round-robin bursts.
- Honours the FIFO's almost-full busy flag and delivers registered full-word writes.
- Keeps a running count of words committed to the FIFO.

Parameters:
- BURST_LEN, 8: maximum words per grant before arbitration is re-evaluated; valid range 1..255.
- CNT_W, 32: width of the committed-word counter.

Ports:
- ClkxCI  in  1  clock
- RstxRI  in  1  reset, synchronous, active-high
- Req0ValidxSI  in  1  requester 0 has a word
- Req0DataxDI  in  32  requester 0 word
- Req0ReadyxSO  out  1  requester 0 word accepted this cycle when valid
- Req1ValidxSI  in  1  requester 1 has a word
- Req1DataxDI  in  32  requester 1 word
- Req1ReadyxSO  out  1  requester 1 word accepted this cycle when valid
- FifoBusyxSI  in  1  FIFO almost-full flag (asserted at length >= depth-8)
- FifoWexSO  out  1  FIFO write enable, registered
- FifoDInxDO  out  32  FIFO write data, registered
- GrantxSO  out  2  one-hot current grant; 00 = idle
- WordCntxDO  out  CNT_W  words written to the FIFO since reset

Behaviour:
- Single clock domain. Reset is synchronous and active-high: any rising edge with RstxRI=1 clears all state.
- Reset values:
  - FifoWexSO=0, FifoDInxDO=0, GrantxSO=00, WordCntxDO=0, both Ready=0.
  - State=IDLE, burst counter=0, last-served pointer=1, so requester 0 wins the first tie.
- Reset during a burst discards any in-flight word; no FIFO write occurs on the cycle after the reset edge.
- States: IDLE, G0, G1. GrantxSO is 01 in G0, 10 in G1, 00 in IDLE.
- Ready (combinational):
  - ReqNReadyxSO = (state==GN) & ~FifoBusyxSI.
  - Ready is never asserted in IDLE.
- Transfer: an accepted word is one where ReqN Valid and Ready are both high on a rising edge.
  - Next cycle: FifoWexSO=1 and FifoDInxDO equals that word. Latency is exactly 1 cycle.
  - Otherwise FifoWexSO=0 and FifoDInxDO holds its last value.
- WordCntxDO increments by 1 on every cycle FifoWexSO=1 and wraps modulo 2^CNT_W.
- IDLE decision (evaluated each cycle):
  - Neither valid: stay in IDLE.
  - One valid: go to that requester's grant.
  - Both valid: grant the requester that is not the last-served one.
  - Entering GN sets last-served=N and clears the burst counter. Arbitration costs 1 idle cycle from IDLE.
- In GN, the burst counter increments on each transfer. Release happens on the same edge when either:
  - a transfer occurs and the burst counter equals BURST_LEN-1; or
  - ReqNValidxSI=0 (checked regardless of busy).
- On release, choose the next state immediately with no idle cycle:
  - other requester valid: go to G(other);
  - else own valid (only possible after burst exhaustion): regrant GN with counter cleared;
  - else go to IDLE.
- FifoBusyxSI=1 stalls the granted requester. The grant, burst counter and last-served pointer all hold. Busy never causes a grant change.
- At most one write is in flight after busy rises. The FIFO's 8-word busy margin absorbs it, so no further flow control is needed.
- A requester dropping Valid without a transfer is legal. A requester must hold its Data stable while Valid=1 and Ready=0.
- BURST_LEN=1 gives strict word-by-word alternation when both requesters are continuously valid.

Test Plan:
- Reset, then Req0Valid=1 with data 0x11111111.. (8 words), Req1 idle, BURST_LEN=8:
  - Grant=01 one cycle after valid;
  - 8 FifoWe pulses with matching data, each 1 cycle after acceptance;
  - WordCnt=8;
  - after the 8th word, regrant G0 with no idle cycle if still valid.
- Both requesters continuously valid, BURST_LEN=4:
  - first grant to Req0;
  - FIFO sees exactly 4 Req0 words, 4 Req1 words, 4 Req0 words, and so on;
  - no idle cycle at the switches.
- FifoBusy held high 5 cycles mid-burst (after word 2 of Req1):
  - Ready low for those 5 cycles and FifoWe low from the following cycle;
  - Grant stays 10;
  - after busy drops the burst resumes, and Req1 completes exactly BURST_LEN total words before switching.
- Req0 drops Valid after 3 words with Req1 valid:
  - Grant switches 01 to 10 on the next edge;
  - last-served=1, so a later tie goes to Req0.
- Reset asserted on the same edge as a Req1 transfer:
  - next cycle FifoWe=0, Grant=00, WordCnt=0;
  - the word is not written.
- CNT_W=4, stream 17 words:
  - WordCnt wraps 15 to 0, then reads 1;
  - all 17 FifoWe pulses are present.
